pulse_scheduler: RTL and testbench

- Shares one fixed-length pulse output among N_REQ independent trigger sources, such as game events or button strobes.
- Rising edges on each request are detected and latched as pending; pending requests are served round-robin.
- Each grant emits a PULSE_LEN-cycle pulse tagged with the requester ID, followed by a GAP_LEN-cycle quiet time.
- Sits between raw event sources and any consumer needing one-shot pulses, replacing per-source monostables.

---
 rtl/pulse_sched_pkg.sv | 16 +
 rtl/rr_picker.sv | 28 ++
 rtl/pulse_scheduler.sv | 116 +++++++++++
 tb/tb_pulse_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse scheduler: FSM state encoding and
// a width helper for requester IDs.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        GAP   = 2'b10
    } state_t;

    // Width needed to encode n requester IDs (never less than one bit).
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: returns the first set bit of pending,
// scanning upward from rr_ptr and wrapping at N_REQ.
module rr_picker
    import pulse_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             valid,
    output logic [ID_W-1:0]  grant
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid = 1'b0;
        grant = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (pending[(int'(rr_ptr) + off) % N_REQ]) begin
                valid = 1'b1;
                grant = ID_W'((int'(rr_ptr) + off) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one fixed-length pulse output among N_REQ trigger sources.
// Rising edges are latched as pending and served round-robin; each grant
// emits a PULSE_LEN-cycle pulse tagged with the requester ID, followed by
// GAP_LEN quiet cycles and one IDLE cycle for arbitration.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 1,
    parameter int ID_W      = id_width(N_REQ),
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic             pulse,
    output logic [ID_W-1:0]  pulse_id,
    output logic             busy,
    output logic [N_REQ-1:0] pending
);

    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] edges;
    logic [N_REQ-1:0] clr;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] counter;
    state_t           state;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_grant;

    assign edges = req & ~req_q;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .valid   (pick_valid),
        .grant   (pick_grant)
    );

    // Clear the granted requester's pending bit in the cycle it is picked.
    always_comb begin
        clr = '0;
        if (state == IDLE && pick_valid) begin
            clr[pick_grant] = 1'b1;
        end
    end

    // Edge history and pending latch; a new edge outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            req_q   <= '0;
            pending <= '0;
        end else begin
            req_q   <= req;
            pending <= (pending & ~clr) | edges;
        end
    end

    // Arbitration, pulse timing and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pulse    <= 1'b0;
            pulse_id <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            counter  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        pulse    <= 1'b1;
                        pulse_id <= pick_grant;
                        busy     <= 1'b1;
                        rr_ptr   <= (pick_grant == ID_W'(N_REQ - 1)) ? '0 : pick_grant + 1'b1;
                        counter  <= CNT_W'(1);
                        state    <= PULSE;
                    end
                end
                PULSE: begin
                    if (counter == CNT_W'(PULSE_LEN)) begin
                        pulse   <= 1'b0;
                        counter <= CNT_W'(1);
                        if (GAP_LEN == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                GAP: begin
                    if (counter == CNT_W'(GAP_LEN)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    pulse <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: main instance with N_REQ=4,
// PULSE_LEN=2, GAP_LEN=1 and a second instance with PULSE_LEN=1, GAP_LEN=0.
module tb_pulse_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       pulse;
    logic [1:0] pulse_id;
    logic       busy;
    logic [3:0] pending;

    logic [3:0] req2;
    logic       pulse2;
    logic [1:0] pulse_id2;
    logic       busy2;
    logic [3:0] pending2;

    int n_checks = 0;
    int n_pass   = 0;

    pulse_scheduler #(.N_REQ(4), .PULSE_LEN(2), .GAP_LEN(1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .pulse(pulse),
        .pulse_id(pulse_id), .busy(busy), .pending(pending)
    );

    pulse_scheduler #(.N_REQ(4), .PULSE_LEN(1), .GAP_LEN(0), .CNT_W(8)) dut_g0 (
        .clk(clk), .reset(reset), .req(req2), .pulse(pulse2),
        .pulse_id(pulse_id2), .busy(busy2), .pending(pending2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled and inputs driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (!busy && !pulse) done = 1;
            else tick();
        end
        n_checks++;
        if (!done) $display("FAIL %s: timeout waiting for idle (busy=%0b pulse=%0b)", name, busy, pulse);
        else n_pass++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        req2  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_checks++; if (pulse !== 1'b0)     $display("FAIL rst_pulse: got %b want 0", pulse);       else n_pass++;
        n_checks++; if (busy !== 1'b0)      $display("FAIL rst_busy: got %b want 0", busy);         else n_pass++;
        n_checks++; if (pending !== 4'b0)   $display("FAIL rst_pending: got %b want 0000", pending); else n_pass++;
        n_checks++; if (pulse_id !== 2'd0)  $display("FAIL rst_id: got %0d want 0", pulse_id);      else n_pass++;
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick(); // E0
        n_checks++; if (pending !== 4'b0100) $display("FAIL single_pend_E0: got %b want 0100", pending); else n_pass++;
        n_checks++; if (pulse !== 1'b0)      $display("FAIL single_pulse_E0: got %b want 0", pulse);     else n_pass++;
        tick(); // E1
        n_checks++; if (pulse !== 1'b1 || pulse_id !== 2'd2)
                        $display("FAIL single_E1: got pulse=%b id=%0d want pulse=1 id=2", pulse, pulse_id); else n_pass++;
        n_checks++; if (busy !== 1'b1 || pending !== 4'b0)
                        $display("FAIL single_E1_state: got busy=%b pend=%b want busy=1 pend=0000", busy, pending); else n_pass++;
        tick(); // E2
        n_checks++; if (pulse !== 1'b1)      $display("FAIL single_E2: got pulse=%b want 1", pulse);     else n_pass++;
        tick(); // E3
        n_checks++; if (pulse !== 1'b0 || busy !== 1'b1)
                        $display("FAIL single_E3: got pulse=%b busy=%b want pulse=0 busy=1", pulse, busy); else n_pass++;
        tick(); // E4
        n_checks++; if (busy !== 1'b0 || pulse_id !== 2'd2)
                        $display("FAIL single_E4: got busy=%b id=%0d want busy=0 id=2", busy, pulse_id); else n_pass++;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_all_rr();
        logic [3:0] exp_pend;
        do_reset();
        req = 4'b1111;
        tick(); // E0
        n_checks++; if (pending !== 4'b1111) $display("FAIL all_pend_E0: got %b want 1111", pending); else n_pass++;
        exp_pend = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_pend = exp_pend << 1;
            tick();
            n_checks++; if (pulse !== 1'b1 || pulse_id !== 2'(k) || pending !== exp_pend)
                            $display("FAIL all_grant%0d: got pulse=%b id=%0d pend=%b want pulse=1 id=%0d pend=%b",
                                     k, pulse, pulse_id, pending, k, exp_pend); else n_pass++;
            tick();
            n_checks++; if (pulse !== 1'b1) $display("FAIL all_high2_%0d: got pulse=%b want 1", k, pulse); else n_pass++;
            tick();
            n_checks++; if (pulse !== 1'b0) $display("FAIL all_gap_%0d: got pulse=%b want 0", k, pulse); else n_pass++;
            tick();
            n_checks++; if (pulse !== 1'b0 || busy !== 1'b0)
                            $display("FAIL all_idle_%0d: got pulse=%b busy=%b want 0 0", k, pulse, busy); else n_pass++;
        end
        req = 4'b0000;
        tick();
    endtask

    // rr_ptr is 0 here; serving id 1 moves it to 2.
    task automatic test_fairness();
        req = 4'b0010;
        tick(); // E0
        tick(); // E1: grant id 1
        n_checks++; if (pulse !== 1'b1 || pulse_id !== 2'd1)
                        $display("FAIL fair_first: got pulse=%b id=%0d want 1 id=1", pulse, pulse_id); else n_pass++;
        req = 4'b1001;
        tick(); // E2
        n_checks++; if (pending !== 4'b1001) $display("FAIL fair_pend: got %b want 1001", pending); else n_pass++;
        tick(); tick(); tick(); // E3 gap, E4 idle, E5 grant
        n_checks++; if (pulse !== 1'b1 || pulse_id !== 2'd3)
                        $display("FAIL fair_id3: got pulse=%b id=%0d want 1 id=3", pulse, pulse_id); else n_pass++;
        tick(); tick(); tick(); tick(); // E9 grant
        n_checks++; if (pulse !== 1'b1 || pulse_id !== 2'd0)
                        $display("FAIL fair_id0: got pulse=%b id=%0d want 1 id=0", pulse, pulse_id); else n_pass++;
        req = 4'b0000;
        wait_idle("fair_drain");
    endtask

    // rr_ptr is 1 here.
    task automatic test_requeue();
        int   rises;
        logic prev;
        req = 4'b0001;
        tick(); // E0
        tick(); // E1: grant id 0
        req = 4'b0011;
        tick(); // E2: pending[1] latched
        req = 4'b0001;
        tick(); // E3 gap
        tick(); // E4 idle
        req = 4'b0011;
        tick(); // E5: grant id 1 and a new edge on req[1]
        n_checks++; if (pulse !== 1'b1 || pulse_id !== 2'd1 || pending !== 4'b0010)
                        $display("FAIL requeue_grant: got pulse=%b id=%0d pend=%b want 1 id=1 pend=0010",
                                 pulse, pulse_id, pending); else n_pass++;
        tick(); tick(); tick(); tick(); // E9: id 1 again
        n_checks++; if (pulse !== 1'b1 || pulse_id !== 2'd1 || pending !== 4'b0000)
                        $display("FAIL requeue_again: got pulse=%b id=%0d pend=%b want 1 id=1 pend=0000",
                                 pulse, pulse_id, pending); else n_pass++;
        req = 4'b0000;
        wait_idle("requeue_drain");
        tick();
        rises = 0;
        prev  = pulse;
        for (int i = 0; i < 18; i++) begin
            req = (i < 10) ? 4'b0010 : 4'b0000;
            tick();
            if (pulse && !prev) rises++;
            prev = pulse;
        end
        n_checks++; if (rises !== 1) $display("FAIL held_level: got %0d pulses want 1", rises); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int rises;
        req = 4'b0001;
        tick(); // E0
        tick(); // E1: grant id 0
        req = 4'b1011;
        tick(); // E2: second pulse cycle
        n_checks++; if (pulse !== 1'b1 || pending !== 4'b1010)
                        $display("FAIL mid_pre: got pulse=%b pend=%b want 1 pend=1010", pulse, pending); else n_pass++;
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        n_checks++; if (pulse !== 1'b0 || busy !== 1'b0 || pending !== 4'b0 || pulse_id !== 2'd0)
                        $display("FAIL mid_reset: got pulse=%b busy=%b pend=%b id=%0d want 0 0 0000 0",
                                 pulse, busy, pending, pulse_id); else n_pass++;
        reset = 1'b0;
        rises = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pulse || busy) rises++;
        end
        n_checks++; if (rises !== 0) $display("FAIL mid_quiet: got %0d active cycles want 0", rises); else n_pass++;
        req = 4'b1001;
        tick(); // E0
        tick(); // E1: rr_ptr back at 0 so id 0 first
        n_checks++; if (pulse !== 1'b1 || pulse_id !== 2'd0)
                        $display("FAIL mid_ptr: got pulse=%b id=%0d want 1 id=0", pulse, pulse_id); else n_pass++;
        req = 4'b0000;
        tick();
        wait_idle("mid_drain1");
        tick();
        wait_idle("mid_drain2");
    endtask

    task automatic test_gap0();
        req2 = 4'b0011;
        tick(); // E0
        n_checks++; if (pending2 !== 4'b0011) $display("FAIL g0_pend: got %b want 0011", pending2); else n_pass++;
        tick(); // E1
        n_checks++; if (pulse2 !== 1'b1 || pulse_id2 !== 2'd0)
                        $display("FAIL g0_first: got pulse=%b id=%0d want 1 id=0", pulse2, pulse_id2); else n_pass++;
        tick(); // E2
        n_checks++; if (pulse2 !== 1'b0 || busy2 !== 1'b0)
                        $display("FAIL g0_low: got pulse=%b busy=%b want 0 0", pulse2, busy2); else n_pass++;
        tick(); // E3
        n_checks++; if (pulse2 !== 1'b1 || pulse_id2 !== 2'd1)
                        $display("FAIL g0_second: got pulse=%b id=%0d want 1 id=1", pulse2, pulse_id2); else n_pass++;
        tick(); // E4
        n_checks++; if (pulse2 !== 1'b0 || busy2 !== 1'b0 || pending2 !== 4'b0)
                        $display("FAIL g0_end: got pulse=%b busy=%b pend=%b want 0 0 0000",
                                 pulse2, busy2, pending2); else n_pass++;
        req2 = 4'b0000;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        req2  = '0;
        test_reset();
        test_single();
        test_all_rr();
        test_fairness();
        test_requeue();
        test_reset_mid();
        test_gap0();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
